// File: rtl/move_seq_pkg.sv
// Address map and state encoding shared by the move sequencer and its users.
package move_seq_pkg;

  // Sequencer register addresses (source and sink share the same map)
  localparam logic [7:0] ADDR_NOP = 8'h00;
  localparam logic [7:0] SEQ_JMP  = 8'h01;
  localparam logic [7:0] SEQ_COND = 8'h02;
  localparam logic [7:0] SEQ_JNZ  = 8'h03;
  localparam logic [7:0] SEQ_HALT = 8'h04;
  localparam logic [7:0] SEQ_CALL = 8'h05;

  // ALU unit address window
  localparam logic [7:0] ALU_LO   = 8'h10;
  localparam logic [7:0] ALU_HI   = 8'h17;

  typedef enum logic {
    ST_HALT = 1'b0,
    ST_RUN  = 1'b1
  } seq_state_e;

endpackage

// File: rtl/move_sequencer.sv
// Move-instruction sequencer: fetches 16-bit {src, dst} moves and issues one
// address pair per cycle. Bus-mapped itself at 0x01-0x05 for jump, condition,
// conditional jump, halt and (optionally) call.
// Optional feature macro: MOVE_SEQ_LINK_EN adds the CALL sink at 0x05 and the
// link register readable at source 0x03.
module move_sequencer
  import move_seq_pkg::*;
#(
  parameter logic [7:0] RESET_PC   = 8'h00,
  parameter bit         AUTO_START = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic [7:0]  pc_out,
  input  logic [15:0] instr_in,
  output logic [7:0]  r_addr,
  output logic [7:0]  w_addr,
  inout  wire  [7:0]  bus,
  output logic        halted
);

  seq_state_e state_q, state_d;
  logic [7:0] pc_q, pc_d;
  logic [7:0] issue_pc_q, issue_pc_d;
  logic       issue_valid_q, issue_valid_d;
  logic [7:0] cond_q, cond_d;
`ifdef MOVE_SEQ_LINK_EN
  logic [7:0] link_q, link_d;
`endif

  logic [7:0] src, dst, ret_pc;
  logic       drv_en;
  logic [7:0] drv_val;

  // A squashed or idle slot presents NOP on both address lines
  assign src    = issue_valid_q ? instr_in[15:8] : ADDR_NOP;
  assign dst    = issue_valid_q ? instr_in[7:0]  : ADDR_NOP;
  assign ret_pc = issue_pc_q + 8'd1;

  assign r_addr = src;
  assign w_addr = dst;
  assign pc_out = pc_q;
  assign halted = (state_q == ST_HALT);

  // Source side: drive the bus only when one of our own registers is read
  always_comb begin
    drv_en  = 1'b0;
    drv_val = 8'h00;
    case (src)
      SEQ_JMP:  begin drv_en = 1'b1; drv_val = ret_pc; end
      SEQ_COND: begin drv_en = 1'b1; drv_val = cond_q; end
`ifdef MOVE_SEQ_LINK_EN
      SEQ_JNZ:  begin drv_en = 1'b1; drv_val = link_q; end
`endif
      default: ;
    endcase
  end

  assign bus = drv_en ? drv_val : 8'hzz;

  // Next-state: sequential advance, then sink-side redirects/halt override it
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    issue_pc_d    = issue_pc_q;
    issue_valid_d = issue_valid_q;
    cond_d        = cond_q;
`ifdef MOVE_SEQ_LINK_EN
    link_d        = link_q;
`endif
    if (state_q == ST_HALT) begin
      if (start) begin
        // Memory already holds mem[pc], so issue it on the very next cycle
        state_d       = ST_RUN;
        issue_pc_d    = pc_q;
        pc_d          = pc_q + 8'd1;
        issue_valid_d = 1'b1;
      end
    end else begin
      issue_pc_d    = pc_q;
      pc_d          = pc_q + 8'd1;
      issue_valid_d = 1'b1;
      case (dst)
        SEQ_JMP: begin
          pc_d          = bus;
          issue_valid_d = 1'b0;
        end
        SEQ_COND: cond_d = bus;
        SEQ_JNZ: begin
          if (cond_q != 8'h00) begin
            pc_d          = bus;
            issue_valid_d = 1'b0;
          end
        end
        SEQ_HALT: begin
          // Keep pc so the instruction fetched this edge is refetched on resume
          state_d       = ST_HALT;
          pc_d          = pc_q;
          issue_pc_d    = issue_pc_q;
          issue_valid_d = 1'b0;
        end
`ifdef MOVE_SEQ_LINK_EN
        SEQ_CALL: begin
          link_d        = ret_pc;
          pc_d          = bus;
          issue_valid_d = 1'b0;
        end
`endif
        default: ;
      endcase
    end
  end

  // State registers with asynchronous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= AUTO_START ? ST_RUN : ST_HALT;
      pc_q          <= RESET_PC;
      issue_pc_q    <= 8'h00;
      issue_valid_q <= 1'b0;
      cond_q        <= 8'h00;
`ifdef MOVE_SEQ_LINK_EN
      link_q        <= 8'h00;
`endif
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      issue_pc_q    <= issue_pc_d;
      issue_valid_q <= issue_valid_d;
      cond_q        <= cond_d;
`ifdef MOVE_SEQ_LINK_EN
      link_q        <= link_d;
`endif
    end
  end

endmodule

// File: tb/tb_move_sequencer.sv
// Bench for move_sequencer: external instruction memory, a simple bus model
// for the ALU window and immediates, and per-cycle expected output rows.
module tb_move_sequencer;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [7:0]  pc_out;
  logic [15:0] instr_in;
  logic [7:0]  r_addr, w_addr;
  wire  [7:0]  bus;
  logic        halted;

  logic [15:0] mem [256];
  logic [7:0]  alu_rd [8];
  logic        ext_en;
  logic [7:0]  ext_val;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       st;
    logic       h;
    logic [7:0] pc;
    logic [7:0] r;
    logic [7:0] w;
    logic [7:0] bv;
    logic       bz;
  } vec_t;

  vec_t tbl [$];
  vec_t exp_q [$];

  move_sequencer #(.RESET_PC(8'h00), .AUTO_START(1'b0)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .pc_out   (pc_out),
    .instr_in (instr_in),
    .r_addr   (r_addr),
    .w_addr   (w_addr),
    .bus      (bus),
    .halted   (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One-cycle synchronous instruction memory
  always @(posedge clk) instr_in <= mem[pc_out];

  // Other bus units: ALU window returns alu_rd, addresses >= 0x08 act as immediates
  always_comb begin
    ext_en  = (r_addr >= 8'h08);
    ext_val = r_addr;
    if (r_addr >= 8'h10 && r_addr <= 8'h17) ext_val = alu_rd[r_addr[2:0]];
  end
  assign bus = ext_en ? ext_val : 8'hzz;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic chk8(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b want %b", nm, act, exp);
    end
  endtask

  // Released bus: z on four-state simulators, may read as 0 on two-state ones
  task automatic chkz(input string nm, input logic [7:0] act);
    checks++;
    if (!(act === 8'hzz || act === 8'h00)) begin
      errors++;
      $display("FAIL %s: got %h want released (z)", nm, act);
    end
  endtask

  task automatic add(input logic st, input logic h, input logic [7:0] pc,
                     input logic [7:0] r, input logic [7:0] w,
                     input logic [7:0] bv, input logic bz);
    vec_t v;
    v.st = st; v.h = h; v.pc = pc; v.r = r; v.w = w; v.bv = bv; v.bz = bz;
    tbl.push_back(v);
  endtask

  task automatic run_rows(input int lo, input int hi);
    vec_t e;
    for (int i = lo; i < hi; i++) begin
      start = tbl[i].st;
      exp_q.push_back(tbl[i]);
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      chk1($sformatf("row%0d halted", i), halted, e.h);
      chk8($sformatf("row%0d pc_out", i), pc_out, e.pc);
      chk8($sformatf("row%0d r_addr", i), r_addr, e.r);
      chk8($sformatf("row%0d w_addr", i), w_addr, e.w);
      if (e.bz) chkz($sformatf("row%0d bus", i), bus);
      else      chk8($sformatf("row%0d bus", i), bus, e.bv);
    end
  endtask

  task automatic reset_checks(input string tag);
    chk1({tag, " halted"}, halted, 1'b1);
    chk8({tag, " pc_out"}, pc_out, 8'h00);
    chk8({tag, " r_addr"}, r_addr, 8'h00);
    chk8({tag, " w_addr"}, w_addr, 8'h00);
    chkz({tag, " bus"}, bus);
  endtask

  int p1_end, p2_end, p3_end;

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    alu_rd[0] = 8'h40; alu_rd[1] = 8'h00; alu_rd[2] = 8'h01; alu_rd[3] = 8'h00;
    alu_rd[4] = 8'h00; alu_rd[5] = 8'h00; alu_rd[6] = 8'h00; alu_rd[7] = 8'h00;

    // Phase 1 program: immediate move, NJZ not/taken, self jump, halt, wrap
    mem[8'h00] = 16'h2A10;
    mem[8'h03] = 16'h1102;  // cond <= 0x00
    mem[8'h04] = 16'h1003;  // JNZ 0x40, not taken
    mem[8'h05] = 16'h0101;  // self jump to 0x06
    mem[8'h06] = 16'h1202;  // cond <= 0x01
    mem[8'h07] = 16'h1003;  // JNZ 0x40, taken
    mem[8'h40] = 16'h0200;  // read cond
    mem[8'h41] = 16'h0801;  // JMP 0x08
    mem[8'h09] = 16'h0004;  // HALT
    mem[8'h0A] = 16'h3310;
    mem[8'h0B] = 16'hFE01;  // JMP 0xFE
    mem[8'hFF] = 16'h0110;  // read issue_pc+1 at 0xFF

    //   st  h    pc     r      w      bus    z
    add(0, 1, 8'h00, 8'h00, 8'h00, 8'h00, 1);
    add(1, 0, 8'h01, 8'h2A, 8'h10, 8'h2A, 0);
    add(0, 0, 8'h02, 8'h00, 8'h00, 8'h00, 1);
    add(0, 0, 8'h03, 8'h00, 8'h00, 8'h00, 1);
    add(0, 0, 8'h04, 8'h11, 8'h02, 8'h00, 0);
    add(0, 0, 8'h05, 8'h10, 8'h03, 8'h40, 0);
    add(0, 0, 8'h06, 8'h01, 8'h01, 8'h06, 0);
    add(0, 0, 8'h06, 8'h00, 8'h00, 8'h00, 1);
    add(0, 0, 8'h07, 8'h12, 8'h02, 8'h01, 0);
    add(0, 0, 8'h08, 8'h10, 8'h03, 8'h40, 0);
    add(0, 0, 8'h40, 8'h00, 8'h00, 8'h00, 1);
    add(0, 0, 8'h41, 8'h02, 8'h00, 8'h01, 0);
    add(0, 0, 8'h42, 8'h08, 8'h01, 8'h08, 0);
    add(0, 0, 8'h08, 8'h00, 8'h00, 8'h00, 1);
    add(0, 0, 8'h09, 8'h00, 8'h00, 8'h00, 1);
    add(0, 0, 8'h0A, 8'h00, 8'h04, 8'h00, 1);
    add(0, 1, 8'h0A, 8'h00, 8'h00, 8'h00, 1);
    add(0, 1, 8'h0A, 8'h00, 8'h00, 8'h00, 1);
    add(0, 1, 8'h0A, 8'h00, 8'h00, 8'h00, 1);
    add(1, 0, 8'h0B, 8'h33, 8'h10, 8'h33, 0);
    add(0, 0, 8'h0C, 8'hFE, 8'h01, 8'hFE, 0);
    add(0, 0, 8'hFE, 8'h00, 8'h00, 8'h00, 1);
    add(0, 0, 8'hFF, 8'h00, 8'h00, 8'h00, 1);
    add(0, 0, 8'h00, 8'h01, 8'h10, 8'h00, 0);
    add(1, 0, 8'h01, 8'h2A, 8'h10, 8'h2A, 0);
    p1_end = tbl.size();

    // Phase 2: jump to 0x20, CALL 0x80 (or ignored without the link feature)
    add(1, 0, 8'h01, 8'h20, 8'h01, 8'h20, 0);
    add(0, 0, 8'h20, 8'h00, 8'h00, 8'h00, 1);
    add(0, 0, 8'h21, 8'h80, 8'h05, 8'h80, 0);
`ifdef MOVE_SEQ_LINK_EN
    add(0, 0, 8'h80, 8'h00, 8'h00, 8'h00, 1);
    add(0, 0, 8'h81, 8'h03, 8'h01, 8'h21, 0);
    add(0, 0, 8'h21, 8'h00, 8'h00, 8'h00, 1);
    add(0, 0, 8'h22, 8'h03, 8'h00, 8'h21, 0);
`else
    add(0, 0, 8'h22, 8'h03, 8'h00, 8'h00, 1);
    add(0, 0, 8'h23, 8'h01, 8'h00, 8'h23, 0);
`endif
    p2_end = tbl.size();

    // Phase 3: first issue after reset reads the link source
`ifdef MOVE_SEQ_LINK_EN
    add(1, 0, 8'h01, 8'h03, 8'h00, 8'h00, 0);
`else
    add(1, 0, 8'h01, 8'h03, 8'h00, 8'h00, 1);
`endif
    p3_end = tbl.size();

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    reset_checks("reset");
    rst_n = 1'b1;

    run_rows(0, p1_end);

    // Asynchronous reset between edges
    #2 rst_n = 1'b0;
    #1;
    reset_checks("midrst1");

    mem[8'h00] = 16'h2001;
    mem[8'h20] = 16'h8005;
    mem[8'h21] = 16'h0300;
    mem[8'h22] = 16'h0100;
    mem[8'h80] = 16'h0301;
    @(posedge clk);
    #1 rst_n = 1'b1;

    run_rows(p1_end, p2_end);

    // Reset while the sequencer itself drives the bus
    #2 rst_n = 1'b0;
    #1;
    reset_checks("midrst2");

    mem[8'h00] = 16'h0300;
    @(posedge clk);
    #1 rst_n = 1'b1;

    run_rows(p2_end, p3_end);

    start = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
